// File: rtl/cpu_pkg.sv
// Shared types and widths for the branch/PC datapath.
package cpu_pkg;

   localparam int PC_W   = 32;
   localparam int DISP_W = 19;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      SAMPLE,
      COMMIT
   } state_t;

   // Sign-extend a branch displacement to PC width
   function automatic logic [PC_W-1:0] sext32(input logic [DISP_W-1:0] d);
      return {{(PC_W-DISP_W){d[DISP_W-1]}}, d};
   endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter register: increment by one or add a sign-extended displacement.
module pc_register
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              clear,
   input  logic              inc,
   input  logic              load,
   input  logic [DISP_W-1:0] disp,
   output logic [PC_W-1:0]   pc
);

   // inc and load are never asserted together by the controlling FSM
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         pc <= '0;
      end else if (load) begin
         pc <= pc + sext32(disp);
      end else if (inc) begin
         pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch sequencing FSM (IDLE/EVAL/SAMPLE/COMMIT) driving the PC register.
// Optional BRANCH_STATS_EN adds saturating branch counters br_total/br_taken.
module branch_pc_unit
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [DISP_W-1:0] ir_c,
   input  logic              pc_inc,
   input  logic              con_in,
   output logic              con_en,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              done,
   output logic              taken,
   output logic              err
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]       br_total,
   output logic [15:0]       br_taken
`endif
);

   state_t            state;
   logic [DISP_W-1:0] ir_q;
   logic              taken_q;
   logic              pc_load;
   logic              pc_step;

   assign busy    = (state != IDLE);
   assign taken   = taken_q;
   assign pc_step = pc_inc && (state == IDLE);
   assign pc_load = (state == COMMIT) && taken_q;

   // taken_q is only non-zero in COMMIT, so it doubles as the taken output
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state   <= IDLE;
         ir_q    <= '0;
         taken_q <= 1'b0;
         con_en  <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         con_en <= 1'b0;
         done   <= 1'b0;
         if ((start || pc_inc) && (state != IDLE)) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  ir_q   <= ir_c;
                  con_en <= 1'b1;
                  state  <= EVAL;
               end
            end
            EVAL: begin
               state <= SAMPLE;
            end
            SAMPLE: begin
               taken_q <= con_in;
               done    <= 1'b1;
               state   <= COMMIT;
            end
            COMMIT: begin
               taken_q <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   pc_register u_pc (
      .clk   (clk),
      .clear (clear),
      .inc   (pc_step),
      .load  (pc_load),
      .disp  (ir_q),
      .pc    (pc)
   );

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         br_total <= '0;
         br_taken <= '0;
      end else if (state == COMMIT) begin
         if (br_total != '1) begin
            br_total <= br_total + 16'd1;
         end
         if (taken_q && (br_taken != '1)) begin
            br_taken <= br_taken + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: expected {taken, pc, latency} queued at
// start, checked when done pulses and on the following cycle.
module tb_branch_pc_unit;

   logic        clk = 1'b0;
   logic        clear;
   logic        start;
   logic [18:0] ir_c;
   logic        pc_inc;
   logic        con_in;
   logic        con_en;
   logic [31:0] pc;
   logic        busy;
   logic        done;
   logic        taken;
   logic        err;
`ifdef BRANCH_STATS_EN
   logic [15:0] br_total;
   logic [15:0] br_taken;
`endif

   typedef struct {
      logic        tk;
      logic [31:0] pc;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   logic [31:0] model_pc;
   logic [31:0] pc_exp;
   bit          pc_pending = 0;

   branch_pc_unit dut (
      .clk    (clk),
      .clear  (clear),
      .start  (start),
      .ir_c   (ir_c),
      .pc_inc (pc_inc),
      .con_in (con_in),
      .con_en (con_en),
      .pc     (pc),
      .busy   (busy),
      .done   (done),
      .taken  (taken),
      .err    (err)
`ifdef BRANCH_STATS_EN
      ,
      .br_total (br_total),
      .br_taken (br_taken)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Output monitor: done pops the scoreboard, pc is compared one cycle later
   always @(negedge clk) begin
      exp_t e;
      if (pc_pending) begin
         check("commit_pc", pc, pc_exp);
         check("done_single", {31'd0, done}, 32'd0);
         check("taken_after", {31'd0, taken}, 32'd0);
         pc_pending = 0;
      end
      if (clear && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("taken", {31'd0, taken}, {31'd0, e.tk});
            check("latency", cyc - e.cyc, 32'd3);
            pc_exp     = e.pc;
            pc_pending = 1;
         end
      end
   end

   task automatic branch(input logic [18:0] d, input logic c, input bit inc,
                         input bit bad_inc, input bit bad_start, input bit abort);
      exp_t e;
      @(posedge clk); #1;
      start  = 1'b1;
      ir_c   = d;
      pc_inc = inc;
      con_in = c;
      if (inc) model_pc = model_pc + 32'd1;
      e.tk  = c;
      e.pc  = c ? model_pc + {{13{d[18]}}, d} : model_pc;
      e.cyc = cyc;
      if (!abort) sb.push_back(e);
      @(negedge clk);
      check("start_con_en", {31'd0, con_en}, 32'd0);
      check("start_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      start  = 1'b0;
      pc_inc = bad_inc;
      ir_c   = ~d;
      @(negedge clk);
      check("eval_con_en", {31'd0, con_en}, 32'd1);
      check("eval_busy", {31'd0, busy}, 32'd1);
      check("eval_pc", pc, model_pc);
      @(posedge clk); #1;
      pc_inc = 1'b0;
      start  = bad_start;
      @(negedge clk);
      check("sample_con_en", {31'd0, con_en}, 32'd0);
      check("sample_done", {31'd0, done}, 32'd0);
      check("sample_pc", pc, model_pc);
      if (abort) begin
         #1 clear = 1'b0;
         start = 1'b0;
         #1;
         check("abort_pc", pc, 32'd0);
         check("abort_busy", {31'd0, busy}, 32'd0);
         check("abort_done", {31'd0, done}, 32'd0);
         check("abort_err", {31'd0, err}, 32'd0);
         model_pc = '0;
         repeat (3) @(negedge clk);
         check("abort_hold_done", {31'd0, done}, 32'd0);
         clear = 1'b1;
         return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !pc_pending) break;
      end
      if (sb.size() != 0 || pc_pending) begin
         check("done_timeout", 32'd1, 32'd0);
         sb.delete();
         pc_pending = 0;
      end
      model_pc = e.pc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear    = 1'b0;
      start    = 1'b0;
      ir_c     = '0;
      pc_inc   = 1'b0;
      con_in   = 1'b0;
      model_pc = '0;
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_con_en", {31'd0, con_en}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_taken", {31'd0, taken}, 32'd0);
      clear = 1'b1;

      // Walk pc up to 0x100 with single increments
      @(posedge clk); #1;
      pc_inc = 1'b1;
      repeat (256) @(posedge clk);
      #1 pc_inc = 1'b0;
      model_pc = 32'h100;
      @(negedge clk);
      check("inc_pc", pc, 32'h100);

      branch(19'h00010, 1'b1, 0, 0, 0, 0);   // 0x110
      branch(19'h7FFF0, 1'b1, 0, 0, 0, 0);   // back to 0x100
      branch(19'h7FFFF, 1'b0, 0, 0, 0, 0);   // not taken, stays 0x100
      check("not_taken_pc", pc, 32'h100);
      branch(19'h7FEF0, 1'b1, 0, 0, 0, 0);   // 0xFFFFFFF0
      check("neg_pc", pc, 32'hFFFF_FFF0);
      branch(19'h00020, 1'b1, 0, 0, 0, 0);   // wraps to 0x10
      check("wrap_pc", pc, 32'h0000_0010);
      check("wrap_err", {31'd0, err}, 32'd0);
      branch(19'h001F0, 1'b1, 0, 0, 0, 0);   // 0x200
      branch(19'h00004, 1'b1, 1, 0, 0, 0);   // inc with start: 0x201 then 0x205
      check("inc_start_pc", pc, 32'h205);

      branch(19'h00008, 1'b1, 0, 1, 0, 0);   // pc_inc in EVAL ignored
      check("busy_inc_pc", pc, 32'h20D);
      check("busy_inc_err", {31'd0, err}, 32'd1);
      branch(19'h00003, 1'b0, 0, 0, 0, 0);
      check("err_sticky", {31'd0, err}, 32'd1);

      branch(19'h00040, 1'b1, 0, 0, 0, 1);   // clear during SAMPLE
      check("post_abort_pc", pc, 32'd0);

      branch(19'h00010, 1'b1, 1, 0, 0, 0);   // 0 -> 1 -> 0x11
      check("post_rst_pc", pc, 32'h11);
      check("post_rst_err", {31'd0, err}, 32'd0);
      branch(19'h00002, 1'b1, 0, 0, 1, 0);   // start in SAMPLE ignored
      check("busy_start_pc", pc, 32'h13);
      check("busy_start_err", {31'd0, err}, 32'd1);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: decoded branch instruction, one-cycle request.
REQ-004 SHALL have port ir_c, input, 19 bits: branch displacement field IR[18:0], two's complement.
REQ-005 SHALL have port pc_inc, input, 1 bit: fetch-stage request to increment PC by 1.
REQ-006 SHALL have port con_in, input, 1 bit: branch-condition result from the CON flip-flop logic.
REQ-007 SHALL have port con_en, output, 1 bit: enable to the CON flip-flop logic.
REQ-008 SHALL have port pc, output, 32 bits: current program counter.
REQ-009 SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port taken, output, 1 bit: registered branch decision, valid while done=1.
REQ-012 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM states IDLE, EVAL, SAMPLE, COMMIT.
REQ-014 In IDLE with start=1, SHALL move to EVAL next cycle; start in any other state SHALL be ignored and SHALL set err.
REQ-015 EVAL SHALL drive con_en=1 for exactly one cycle, then move to SAMPLE.
REQ-016 SAMPLE SHALL register con_in into taken_q, then move to COMMIT.
REQ-017 COMMIT SHALL load pc <= pc + sext32(ir_c) when taken_q=1, hold pc otherwise, drive done=1, and return to IDLE.
REQ-018 Latency SHALL be fixed: done asserts in the third cycle after the start cycle.
REQ-019 ir_c SHALL be captured into a register on start acceptance; later changes to ir_c SHALL not affect the target.
REQ-020 Target addition SHALL be 32-bit modulo 2^32; wrap-around is legal and SHALL not set err.
REQ-021 pc_inc in IDLE SHALL increment pc by 1 (mod 2^32) next cycle.
REQ-022 pc_inc and start together in IDLE SHALL apply the increment and accept start in the same cycle.
REQ-023 pc_inc while busy=1 SHALL be ignored and SHALL set err.
REQ-024 con_en, done and taken SHALL be 0 outside their defined states.

Reset
REQ-025 clear=0 SHALL immediately force state=IDLE, pc=0, taken_q=0, err=0, con_en=0, done=0, busy=0, regardless of clk.
REQ-026 Reset mid-branch SHALL abandon the branch with no PC update and no done pulse.
REQ-027 On release of clear, the first rising edge SHALL accept start or pc_inc normally.

Configuration
REQ-028 Macro BRANCH_STATS_EN, when defined, SHALL add outputs br_total[15:0] and br_taken[15:0], incremented in COMMIT, saturating at 16'hFFFF, cleared by clear.
REQ-029 Without BRANCH_STATS_EN, these ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-030 A shared package cpu_pkg SHALL hold the FSM state enum, PC_W=32 and DISP_W=19.
REQ-031 The PC register, with its increment/load muxing, SHALL be a sub-module pc_register; the FSM SHALL stay in branch_pc_unit.

Verification
REQ-032 pc=0x100, start, ir_c=0x00010, con_in=1 in SAMPLE -> done in the third cycle, taken=1, pc=0x110.
REQ-033 pc=0x100, start, ir_c=0x7FFFF (-1), con_in=0 -> taken=0, pc stays 0x100.
REQ-034 pc=0xFFFFFFF0, ir_c=0x00020, taken -> pc=0x00000010, err=0.
REQ-035 pc_inc and start in the same IDLE cycle, ir_c=4, taken, starting pc=0x200 -> pc=0x201 next cycle, then 0x205 at COMMIT.
REQ-036 pc_inc in EVAL -> pc unchanged, err=1 and held until clear.
REQ-037 clear asserted during SAMPLE -> pc=0 and state IDLE immediately, with no done pulse.
